// File: rtl/sram_sa_multiport_if.sv
// Bus bundle for the suffix-array sample memory: streaming load, single-word update
// and NUM_RD independent read ports.
interface sram_sa_multiport_if #(
    parameter int unsigned WIDTHS     = 1920,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2
);
    logic                         load_start;
    logic                         load_valid;
    logic [WIDTHS-1:0]            load_data;
    logic                         load_ready;
    logic                         load_done;
    logic                         busy;
    logic                         loaded;
    logic                         wEn;
    logic [ADDR_WIDTH-1:0]        wAddr;
    logic [WIDTHS-1:0]            wData;
    logic [NUM_RD-1:0]            rEn;
    logic [NUM_RD*ADDR_WIDTH-1:0] rAddr;
    logic [NUM_RD*WIDTHS-1:0]     rData;
    logic [NUM_RD-1:0]            rValid;
    logic [NUM_RD-1:0]            rErr;

    modport master (
        output load_start, load_valid, load_data, wEn, wAddr, wData, rEn, rAddr,
        input  load_ready, load_done, busy, loaded, rData, rValid, rErr
    );

    modport slave (
        input  load_start, load_valid, load_data, wEn, wAddr, wData, rEn, rAddr,
        output load_ready, load_done, busy, loaded, rData, rValid, rErr
    );
endinterface

// File: rtl/sram_sa_multiport.sv
// Suffix-array sample memory: run-time streaming load via IDLE/LOAD/READY FSM, one update
// write port and NUM_RD registered read ports with valid/error flags.
module sram_sa_multiport #(
    parameter int unsigned DEPTH      = 18,
    parameter int unsigned WIDTHS     = 1920,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned WR_BYPASS  = 1
) (
    input logic                clk,
    input logic                rst_n,
    sram_sa_multiport_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StLoad, StReady} state_t;

    localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  loadReady;
    logic                  loadDone;
    logic                  busyQ;
    logic                  loadedQ;

    logic [WIDTHS-1:0]     mem [DEPTH];
    logic                  loadWe;
    logic                  updWe;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [WIDTHS-1:0]     memData;

    // Load stream and update port are exclusive by state, so one write port suffices.
    always_comb begin
        loadWe  = (state == StLoad) && bus.load_valid && !bus.load_start;
        updWe   = (state == StReady) && bus.wEn && ({1'b0, bus.wAddr} < DepthW);
        memWe   = loadWe || updWe;
        memAddr = loadWe ? ptr : bus.wAddr;
        memData = loadWe ? bus.load_data : bus.wData;
    end

    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[memAddr] <= memData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            ptr       <= '0;
            loadReady <= 1'b0;
            loadDone  <= 1'b0;
            busyQ     <= 1'b0;
            loadedQ   <= 1'b0;
        end else begin
            loadDone <= 1'b0;
            case (state)
                StIdle: begin
                    if (bus.load_start) begin
                        state     <= StLoad;
                        ptr       <= '0;
                        loadReady <= 1'b1;
                        busyQ     <= 1'b1;
                    end
                end
                StLoad: begin
                    if (bus.load_start) begin
                        ptr <= '0;
                    end else if (bus.load_valid) begin
                        if (ptr == LastAddr) begin
                            state     <= StReady;
                            ptr       <= '0;
                            loadReady <= 1'b0;
                            busyQ     <= 1'b0;
                            loadedQ   <= 1'b1;
                            loadDone  <= 1'b1;
                        end else begin
                            ptr <= ptr + ADDR_WIDTH'(1);
                        end
                    end
                end
                StReady: begin
                    if (bus.load_start) begin
                        state     <= StLoad;
                        ptr       <= '0;
                        loadReady <= 1'b1;
                        busyQ     <= 1'b1;
                        loadedQ   <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.load_ready = loadReady;
    assign bus.load_done  = loadDone;
    assign bus.busy       = busyQ;
    assign bus.loaded     = loadedQ;

    logic [ADDR_WIDTH-1:0] portAddr [NUM_RD];
    logic                  rdEn     [NUM_RD];
    logic                  rdErr    [NUM_RD];
    logic [WIDTHS-1:0]     rdNext   [NUM_RD];

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            portAddr[i] = bus.rAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            rdEn[i]     = (state == StReady) && bus.rEn[i];
            rdErr[i]    = rdEn[i] && ({1'b0, portAddr[i]} >= DepthW);
            if ({1'b0, portAddr[i]} >= DepthW) begin
                rdNext[i] = '0;
            end else if ((WR_BYPASS != 0) && updWe && (bus.wAddr == portAddr[i])) begin
                rdNext[i] = bus.wData;
            end else begin
                rdNext[i] = mem[portAddr[i]];
            end
        end
    end

    logic [WIDTHS-1:0] s1Data  [NUM_RD];
    logic              s1Valid [NUM_RD];
    logic              s1Err   [NUM_RD];

    // Data holds when a port is idle; valid and error are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RD; i++) begin
                s1Data[i]  <= '0;
                s1Valid[i] <= 1'b0;
                s1Err[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                s1Valid[i] <= rdEn[i];
                s1Err[i]   <= rdErr[i];
                if (rdEn[i]) begin
                    s1Data[i] <= rdNext[i];
                end
            end
        end
    end

    logic [WIDTHS-1:0] outData  [NUM_RD];
    logic              outValid [NUM_RD];
    logic              outErr   [NUM_RD];

    if (RD_LATENCY == 2) begin : gLat2
        logic [WIDTHS-1:0] s2Data  [NUM_RD];
        logic              s2Valid [NUM_RD];
        logic              s2Err   [NUM_RD];

        // Runs independently of FSM state so in-flight reads survive a load_start.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < NUM_RD; i++) begin
                    s2Data[i]  <= '0;
                    s2Valid[i] <= 1'b0;
                    s2Err[i]   <= 1'b0;
                end
            end else begin
                for (int i = 0; i < NUM_RD; i++) begin
                    s2Valid[i] <= s1Valid[i];
                    s2Err[i]   <= s1Err[i];
                    if (s1Valid[i]) begin
                        s2Data[i] <= s1Data[i];
                    end
                end
            end
        end

        always_comb begin
            for (int i = 0; i < NUM_RD; i++) begin
                outData[i]  = s2Data[i];
                outValid[i] = s2Valid[i];
                outErr[i]   = s2Err[i];
            end
        end
    end else begin : gLat1
        always_comb begin
            for (int i = 0; i < NUM_RD; i++) begin
                outData[i]  = s1Data[i];
                outValid[i] = s1Valid[i];
                outErr[i]   = s1Err[i];
            end
        end
    end

    always_comb begin
        bus.rData  = '0;
        bus.rValid = '0;
        bus.rErr   = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rData[i*WIDTHS +: WIDTHS] = outData[i];
            bus.rValid[i]                 = outValid[i];
            bus.rErr[i]                   = outErr[i];
        end
    end
endmodule

// File: tb/tb_sram_sa_multiport.sv
// Bench for sram_sa_multiport: table-driven reads plus hand sequences for load, bypass
// and reset corners, with a per-port scoreboard checked at the read latency.
module tb_sram_sa_multiport;
    localparam int unsigned DEPTH      = 18;
    localparam int unsigned WIDTHS     = 1920;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_RD     = 2;
    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned BYPASS     = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sram_sa_multiport_if #(.WIDTHS(WIDTHS), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD)) bus ();

    sram_sa_multiport #(
        .DEPTH(DEPTH), .WIDTHS(WIDTHS), .ADDR_WIDTH(ADDR_WIDTH), .NUM_RD(NUM_RD),
        .RD_LATENCY(RD_LAT), .WR_BYPASS(BYPASS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic check(string name, logic [WIDTHS-1:0] got, logic [WIDTHS-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h required %h (low 64 bits)", name, got[63:0], exp[63:0]);
    endtask

    function automatic logic [WIDTHS-1:0] word(int k);
        logic [WIDTHS-1:0] w;
        logic [7:0] b;
        b = 8'(k);
        for (int i = 0; i < WIDTHS / 8; i++) w[i*8 +: 8] = b;
        return w;
    endfunction

    typedef struct {
        int                due;
        logic [WIDTHS-1:0] data;
        logic              err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model of memory contents and load state
    logic [WIDTHS-1:0] mMem [DEPTH];
    int mPtr = 0;
    bit mLoad = 0;
    bit mReady = 0;

    task automatic pushExp(int p, logic [WIDTHS-1:0] d, logic e);
        exp_t x;
        x.due = cyc + RD_LAT;
        x.data = d;
        x.err = e;
        if (p == 0) q0.push_back(x);
        else q1.push_back(x);
    endtask

    task automatic tick(bit pushReads = 1);
        logic [ADDR_WIDTH-1:0] a;
        if (mReady && pushReads) begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (bus.rEn[p]) begin
                    a = bus.rAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
                    if (a >= DEPTH) pushExp(p, '0, 1'b1);
                    else if (BYPASS != 0 && bus.wEn && bus.wAddr == a) pushExp(p, bus.wData, 1'b0);
                    else pushExp(p, mMem[a], 1'b0);
                end
            end
        end
        if (mReady && bus.wEn && bus.wAddr < DEPTH) mMem[bus.wAddr] = bus.wData;
        if (mLoad) begin
            if (bus.load_start) mPtr = 0;
            else if (bus.load_valid) begin
                mMem[mPtr] = bus.load_data;
                if (mPtr == DEPTH - 1) begin
                    mPtr = 0;
                    mLoad = 0;
                    mReady = 1;
                end else mPtr++;
            end
        end else if (bus.load_start) begin
            mLoad = 1;
            mReady = 0;
            mPtr = 0;
        end
        @(negedge clk);
        bus.load_start = 1'b0;
        bus.wEn = 1'b0;
        bus.rEn = '0;
    endtask

    task automatic chkPort(int p);
        exp_t e;
        bit has;
        logic v;
        v = bus.rValid[p];
        has = 0;
        if (p == 0) begin
            if (q0.size() != 0) if (q0[0].due <= cyc) begin has = 1; e = q0.pop_front(); end
        end else begin
            if (q1.size() != 0) if (q1[0].due <= cyc) begin has = 1; e = q1.pop_front(); end
        end
        if (has) begin
            check($sformatf("rValid%0d@%0d", p, cyc), v, 1);
            check($sformatf("rErr%0d@%0d", p, cyc), bus.rErr[p], e.err);
            check($sformatf("rData%0d@%0d", p, cyc), bus.rData[p*WIDTHS +: WIDTHS], e.data);
        end else if (v) begin
            check($sformatf("unexpected rValid%0d@%0d", p, cyc), v, 0);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chkPort(0);
            chkPort(1);
        end
    end

    typedef struct {
        logic [1:0] en;
        int         a0;
        int         a1;
        logic [1:0] expErr;
        int         w0;  // expected word index, -1 means zero data
        int         w1;
    } vec_t;

    vec_t vecs[8];

    task automatic loadAll(int base, bit toggle);
        bus.load_start = 1'b1;
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data = word(base + k);
            check("load_ready in LOAD", bus.load_ready, 1);
            tick();
            if (toggle && k < DEPTH - 1) begin
                bus.load_valid = 1'b0;
                tick();
            end
        end
        bus.load_valid = 1'b0;
        check("load_done pulse", bus.load_done, 1);
        check("loaded after load", bus.loaded, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data = '0;
        bus.wEn = 1'b0;
        bus.wAddr = '0;
        bus.wData = '0;
        bus.rEn = '0;
        bus.rAddr = '0;

        vecs[0] = '{2'b11, 3, 17, 2'b00, 3, 17};
        vecs[1] = '{2'b01, 20, 0, 2'b01, -1, 0};
        vecs[2] = '{2'b11, 20, 5, 2'b01, -1, 5};
        vecs[3] = '{2'b10, 0, 31, 2'b10, 0, -1};
        vecs[4] = '{2'b11, 0, 0, 2'b00, 0, 0};
        vecs[5] = '{2'b11, 17, 18, 2'b10, 17, -1};
        vecs[6] = '{2'b00, 1, 2, 2'b00, 0, 0};
        vecs[7] = '{2'b11, 9, 9, 2'b00, 9, 9};

        repeat (3) @(negedge clk);
        check("reset loaded", bus.loaded, 0);
        check("reset busy", bus.busy, 0);
        check("reset load_ready", bus.load_ready, 0);
        check("reset load_done", bus.load_done, 0);
        check("reset rValid", bus.rValid, 0);
        check("reset rErr", bus.rErr, 0);
        check("reset rData0", bus.rData[0 +: WIDTHS], 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reads in IDLE are ignored
        bus.rEn = 2'b11;
        bus.rAddr = {5'd2, 5'd1};
        tick();

        // Full load with load_valid held high, reads during LOAD ignored
        bus.load_start = 1'b1;
        tick();
        check("busy in LOAD", bus.busy, 1);
        bus.load_valid = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            bus.load_data = word(k);
            check("load_ready held", bus.load_ready, 1);
            bus.rEn = 2'b11;
            bus.rAddr = {ADDR_WIDTH'(k), ADDR_WIDTH'(k)};
            tick();
        end
        bus.load_valid = 1'b0;
        check("load_done first READY", bus.load_done, 1);
        check("loaded first READY", bus.loaded, 1);
        check("load_ready READY", bus.load_ready, 0);
        check("busy READY", bus.busy, 0);
        tick();
        check("load_done one cycle", bus.load_done, 0);
        check("loaded holds", bus.loaded, 1);

        // Table-driven reads against a freshly loaded image
        for (int i = 0; i < 8; i++) begin
            bus.rEn = vecs[i].en;
            bus.rAddr = {ADDR_WIDTH'(vecs[i].a1), ADDR_WIDTH'(vecs[i].a0)};
            if (vecs[i].en[0]) pushExp(0, vecs[i].w0 < 0 ? '0 : word(vecs[i].w0), vecs[i].expErr[0]);
            if (vecs[i].en[1]) pushExp(1, vecs[i].w1 < 0 ? '0 : word(vecs[i].w1), vecs[i].expErr[1]);
            tick(0);
        end
        tick();
        check("rData0 holds", bus.rData[0 +: WIDTHS], word(9));
        check("rData1 holds", bus.rData[WIDTHS +: WIDTHS], word(9));

        // Read-during-write same address, then read back
        bus.wEn = 1'b1;
        bus.wAddr = 5'd4;
        bus.wData = '1;
        bus.rEn = 2'b01;
        bus.rAddr = {5'd0, 5'd4};
        tick();
        bus.rEn = 2'b11;
        bus.rAddr = {5'd4, 5'd4};
        tick();
        bus.wEn = 1'b1;
        bus.wAddr = 5'd20;
        bus.wData = word(77);
        tick();
        tick();

        // Reload with toggling valid and a mid-load restart
        bus.load_start = 1'b1;
        tick();
        check("loaded drops", bus.loaded, 0);
        for (int k = 0; k < 3; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data = word(50 + k);
            tick();
            bus.load_valid = 1'b0;
            tick();
        end
        bus.load_start = 1'b1;
        bus.load_valid = 1'b1;
        bus.load_data = word(99);
        tick();
        bus.load_valid = 1'b0;
        check("restart keeps LOAD", bus.load_ready, 1);
        for (int k = 0; k < DEPTH; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data = word(k);
            if (k == DEPTH - 1) check("not loaded before last", bus.loaded, 0);
            tick();
            if (k < DEPTH - 1) begin
                bus.load_valid = 1'b0;
                tick();
            end
        end
        bus.load_valid = 1'b0;
        check("toggle load_done", bus.load_done, 1);
        check("toggle loaded", bus.loaded, 1);
        bus.rEn = 2'b11;
        bus.rAddr = {5'd5, 5'd5};
        tick();
        bus.rEn = 2'b11;
        bus.rAddr = {5'd0, 5'd4};
        tick();
        tick();

        // Reset after 7 load words
        bus.load_start = 1'b1;
        tick();
        bus.load_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.load_data = word(120 + k);
            tick();
        end
        bus.load_valid = 1'b0;
        rst_n = 1'b0;
        mLoad = 0;
        mReady = 0;
        mPtr = 0;
        #1;
        check("midreset loaded", bus.loaded, 0);
        check("midreset busy", bus.busy, 0);
        check("midreset load_ready", bus.load_ready, 0);
        check("midreset rValid", bus.rValid, 0);
        check("midreset rData0", bus.rData[0 +: WIDTHS], 0);
        check("midreset rData1", bus.rData[WIDTHS +: WIDTHS], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.rEn = 2'b11;
        bus.rAddr = {5'd2, 5'd1};
        tick();
        bus.wEn = 1'b1;
        bus.wAddr = 5'd2;
        bus.wData = '1;
        tick();

        // Full reload; an update write mid-load must be ignored
        bus.load_start = 1'b1;
        tick();
        for (int k = 0; k < DEPTH; k++) begin
            bus.load_valid = 1'b1;
            bus.load_data = word(30 + k);
            bus.rEn = 2'b01;
            bus.rAddr = {5'd0, 5'd0};
            tick();
            if (k == 10) begin
                bus.load_valid = 1'b0;
                bus.wEn = 1'b1;
                bus.wAddr = 5'd3;
                bus.wData = '1;
                tick();
            end
        end
        bus.load_valid = 1'b0;
        check("reload loaded", bus.loaded, 1);
        bus.rEn = 2'b11;
        bus.rAddr = {5'd2, 5'd7};
        tick();
        bus.rEn = 2'b11;
        bus.rAddr = {5'd17, 5'd3};
        tick();
        repeat (4) tick();

        check("scoreboard drained", q0.size() + q1.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
